pc_stack: RTL and testbench

PC_STACK -- requirements
Module: pc_stack

---
 rtl/pc_stack.sv | 145 ++++++++++++++
 tb/tb_pc_stack.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// pc_stack: program counter with a return-address stack.
//
// One operation is performed per clock edge, chosen by fixed priority
// call > ret > load > rel > inc. Stack overflow and underflow raise sticky
// error flags. A one-cycle wrap pulse follows any inc/rel that leaves the
// unsigned PC range.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   inc, load, rel, call, ret    operation requests
//   addr_in                      jump/call target
//   rel_off                      signed branch offset
//   ep                           bus output enable (no effect on state)
//   clr_err                      clears the sticky error flags
//   pc                           current PC
//   bus_out, bus_oe              gated PC for the top-level bus mux
//   sp, full, empty              stack occupancy
//   err_ovf, err_unf             sticky overflow / underflow flags
//   wrap                         registered wrap pulse
module pc_stack #(
    parameter int                ADDR_W      = 4,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               inc,
    input  logic                               load,
    input  logic [ADDR_W-1:0]                  addr_in,
    input  logic                               rel,
    input  logic [ADDR_W-1:0]                  rel_off,
    input  logic                               call,
    input  logic                               ret,
    input  logic                               ep,
    input  logic                               clr_err,
    output logic [ADDR_W-1:0]                  pc,
    output logic [ADDR_W-1:0]                  bus_out,
    output logic                               bus_oe,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               full,
    output logic                               empty,
    output logic                               err_ovf,
    output logic                               err_unf,
    output logic                               wrap
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_unf_q, err_unf_d;
    logic              wrap_q, wrap_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W+1:0] rel_sum;
    logic [ADDR_W-1:0] stack_top;
    logic              is_full, is_empty;
    logic              push, ovf_set, unf_set;

    assign pc_inc   = pc_q + ADDR_W'(1);
    // Two guard bits: a true signed sum outside 0..2^ADDR_W-1 shows up as a
    // nonzero value in the top two bits (01 = above max, 11 = below zero).
    assign rel_sum  = {2'b00, pc_q} + {{2{rel_off[ADDR_W-1]}}, rel_off};
    assign is_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign is_empty = (sp_q == '0);

    always_comb begin
        stack_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) stack_top = stack_q[i];
        end
    end

    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        wrap_d  = 1'b0;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (call) begin
            if (is_full) begin
                ovf_set = 1'b1;
            end else begin
                push = 1'b1;
                sp_d = sp_q + SP_W'(1);
                pc_d = addr_in;
            end
        end else if (ret) begin
            if (is_empty) begin
                unf_set = 1'b1;
            end else begin
                sp_d = sp_q - SP_W'(1);
                pc_d = stack_top;
            end
        end else if (load) begin
            pc_d = addr_in;
        end else if (rel) begin
            pc_d   = rel_sum[ADDR_W-1:0];
            wrap_d = |rel_sum[ADDR_W+1:ADDR_W];
        end else if (inc) begin
            pc_d   = pc_inc;
            wrap_d = &pc_q;
        end
        // A new error beats a simultaneous clear.
        err_ovf_d = ovf_set | (err_ovf_q & ~clr_err);
        err_unf_d = unf_set | (err_unf_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_VEC;
            sp_q      <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
            wrap_q    <= wrap_d;
        end
    end

    // Stack storage is never reset; entries at or above sp are unobservable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push && !reset && sp_q == SP_W'(i)) stack_q[i] <= pc_inc;
        end
    end

    assign pc      = pc_q;
    assign bus_out = ep ? pc_q : '0;
    assign bus_oe  = ep;
    assign sp      = sp_q;
    assign full    = is_full;
    assign empty   = is_empty;
    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: self-checking bench for pc_stack (ADDR_W=4, STACK_DEPTH=4).
// Directed vector table, hand-written reset/bus sequences, then random
// stimulus checked against a queue-based reference model.
module tb_pc_stack;

    localparam int AW  = 4;
    localparam int DEP = 4;
    localparam int MOD = 1 << AW;
    localparam int SPW = $clog2(DEP + 1);

    logic           clk = 1'b0;
    logic           reset;
    logic           inc, load, rel, call, ret, ep, clr_err;
    logic [AW-1:0]  addr_in, rel_off;
    logic [AW-1:0]  pc, bus_out;
    logic           bus_oe, full, empty, err_ovf, err_unf, wrap;
    logic [SPW-1:0] sp;

    int total = 0;
    int bad   = 0;

    pc_stack #(.ADDR_W(AW), .STACK_DEPTH(DEP), .RESET_VEC('0)) dut (
        .clk(clk), .reset(reset), .inc(inc), .load(load), .addr_in(addr_in),
        .rel(rel), .rel_off(rel_off), .call(call), .ret(ret), .ep(ep),
        .clr_err(clr_err), .pc(pc), .bus_out(bus_out), .bus_oe(bus_oe),
        .sp(sp), .full(full), .empty(empty), .err_ovf(err_ovf),
        .err_unf(err_unf), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int e_pc, input int e_sp,
                             input int e_ovf, input int e_unf, input int e_wrap);
        chk({tag, "_pc"}, int'(pc), e_pc);
        chk({tag, "_sp"}, int'(sp), e_sp);
        chk({tag, "_full"}, int'(full), int'(e_sp == DEP));
        chk({tag, "_empty"}, int'(empty), int'(e_sp == 0));
        chk({tag, "_ovf"}, int'(err_ovf), e_ovf);
        chk({tag, "_unf"}, int'(err_unf), e_unf);
        chk({tag, "_wrap"}, int'(wrap), e_wrap);
    endtask

    task automatic drive(input bit c, input bit r, input bit l, input bit rl,
                         input bit i, input bit clr, input int a, input int o);
        call = c; ret = r; load = l; rel = rl; inc = i; clr_err = clr;
        addr_in = AW'(a); rel_off = AW'(o);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: integer PC, queue as the LIFO stack.
    int m_pc;
    int m_q[$];
    int m_ovf, m_unf, m_wrap;

    task automatic model_reset();
        m_pc = 0; m_q.delete(); m_ovf = 0; m_unf = 0; m_wrap = 0;
    endtask

    task automatic model_step(input bit c, input bit r, input bit l, input bit rl,
                              input bit i, input bit clr, input int a, input int o);
        int s;
        int new_ovf = 0;
        int new_unf = 0;
        m_wrap = 0;
        if (c) begin
            if (m_q.size() == DEP) new_ovf = 1;
            else begin
                m_q.push_back((m_pc + 1) % MOD);
                m_pc = a;
            end
        end else if (r) begin
            if (m_q.size() == 0) new_unf = 1;
            else m_pc = m_q.pop_back();
        end else if (l) begin
            m_pc = a;
        end else if (rl) begin
            s = m_pc + ((o >= MOD / 2) ? o - MOD : o);
            m_wrap = (s < 0 || s >= MOD) ? 1 : 0;
            m_pc = ((s % MOD) + MOD) % MOD;
        end else if (i) begin
            s = m_pc + 1;
            m_wrap = (s >= MOD) ? 1 : 0;
            m_pc = s % MOD;
        end
        m_ovf = new_ovf ? 1 : (clr ? 0 : m_ovf);
        m_unf = new_unf ? 1 : (clr ? 0 : m_unf);
    endtask

    typedef struct {
        bit c, r, l, rl, i, clr;
        int addr, off;
        int e_pc, e_sp, e_ovf, e_unf, e_wrap;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit c, input bit r, input bit l, input bit rl,
                       input bit i, input bit clr, input int a, input int o,
                       input int p, input int s, input int ov, input int un, input int w);
        vec_t v;
        v = '{c: c, r: r, l: l, rl: rl, i: i, clr: clr, addr: a, off: o,
              e_pc: p, e_sp: s, e_ovf: ov, e_unf: un, e_wrap: w};
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1; ep = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk_state("rst", 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;

        // Count through the full range: 0..15, 0, 1 with a single wrap pulse.
        inc = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk($sformatf("inc%0d_pc", k), int'(pc), k % MOD);
            chk($sformatf("inc%0d_wrap", k), int'(wrap), int'(k == MOD));
        end
        inc = 1'b0;
        tick();
        chk("inc_after_wrap", int'(wrap), 0);
        reset = 1'b1; #1; reset = 1'b0;

        //   c  r  l rl  i clr addr off   pc sp ovf unf wrap
        add(0, 0, 1, 0, 0, 0,  5,  0,    5, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 12,  0,   12, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  3,  0,    3, 2, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,  0,  0,   13, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,  0,  0,    6, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,  0,  0,    6, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1,  0,  0,    6, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0,  2,  0,    2, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0,  9,  0,    9, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,  0,  0,    3, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0,  2,  0,    2, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0,  0, 14,    0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0,  0, 15,   15, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,  0,  0,   15, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0,  0,  0,    0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 1,  0,  0,    0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1,  0,  0,    0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  1,  0,    1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  2,  0,    2, 2, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  3,  0,    3, 3, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  4,  0,    4, 4, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  7,  0,    4, 4, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1,  7,  0,    4, 4, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,  0,  0,    4, 4, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,  0,  0,    4, 3, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,  0,  0,    3, 2, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,  0,  0,    2, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,  0,  0,    1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 10,  3,   10, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0,  0,  3,   13, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0,  0,  5,    2, 0, 0, 0, 1);

        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].c, tbl[n].r, tbl[n].l, tbl[n].rl, tbl[n].i, tbl[n].clr,
                  tbl[n].addr, tbl[n].off);
            tick();
            chk_state($sformatf("row%0d", n), tbl[n].e_pc, tbl[n].e_sp,
                      tbl[n].e_ovf, tbl[n].e_unf, tbl[n].e_wrap);
        end

        // Asynchronous reset in the middle of a call, then release with the
        // call still requested: the first edge afterwards performs it.
        drive(1, 0, 0, 0, 0, 0, 9, 0);
        tick();
        chk_state("pre_rst", 9, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 5, 0);
        #3 reset = 1'b1;
        #1;
        chk_state("async_rst", 0, 0, 0, 0, 0);
        tick();
        chk_state("held_rst", 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        tick();
        chk_state("post_rst", 5, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        ep = 1'b1; #1;
        chk("ep1_bus", int'(bus_out), 5);
        chk("ep1_oe", int'(bus_oe), 1);
        ep = 1'b0; #1;
        chk("ep0_bus", int'(bus_out), 0);
        chk("ep0_oe", int'(bus_oe), 0);

        // Random phase against the reference model.
        reset = 1'b1; #1; reset = 1'b0;
        model_reset();
        for (int n = 0; n < 400; n++) begin
            bit c, r, l, rl, i, clr;
            int a, o;
            c   = ($urandom_range(0, 5) == 0);
            r   = ($urandom_range(0, 4) == 0);
            l   = ($urandom_range(0, 5) == 0);
            rl  = ($urandom_range(0, 2) == 0);
            i   = ($urandom_range(0, 1) == 0);
            clr = ($urandom_range(0, 9) == 0);
            a   = $urandom_range(0, MOD - 1);
            o   = $urandom_range(0, MOD - 1);
            drive(c, r, l, rl, i, clr, a, o);
            ep = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("rnd%0d_bus", n), int'(bus_out), ep ? m_pc : 0);
            chk($sformatf("rnd%0d_oe", n), int'(bus_oe), int'(ep));
            model_step(c, r, l, rl, i, clr, a, o);
            tick();
            chk_state($sformatf("rnd%0d", n), m_pc, m_q.size(), m_ovf, m_unf, m_wrap);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
